// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: X/Y counters, region decodes, frame counter,
// and HSYNC/VSYNC/DE delayed through a configurable register pipeline.
module vga_timing_gen #(
   parameter int   H_VISIBLE_AREA = 800,
   parameter int   H_FRONT_PORCH  = 40,
   parameter int   H_SYNC_PULSE   = 128,
   parameter int   H_BACK_PORCH   = 88,
   parameter int   V_VISIBLE_AREA = 600,
   parameter int   V_FRONT_PORCH  = 1,
   parameter int   V_SYNC_PULSE   = 4,
   parameter int   V_BACK_PORCH   = 23,
   parameter logic HSYNC_POLARITY = 1'b0,
   parameter logic VSYNC_POLARITY = 1'b0,
   parameter int   PIPE_DELAY     = 2,
   parameter int   CW             = 11
) (
   input  logic          VGA_CLK,
   input  logic          VGA_RST_N,
   input  logic          EN,
   output logic [CW-1:0] X,
   output logic [CW-1:0] Y,
   output logic          ACTIVE,
   output logic          LINE_START,
   output logic          FRAME_START,
   output logic [7:0]    FRAME_COUNT,
   output logic          VGA_HS,
   output logic          VGA_VS,
   output logic          VGA_DE
);

   localparam int H_TOTAL = H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH;
   localparam int V_TOTAL = V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

   // One extra bit so a region ending exactly at 2^CW does not wrap to zero.
   localparam logic [CW:0] H_VIS_END = (CW+1)'(H_VISIBLE_AREA);
   localparam logic [CW:0] V_VIS_END = (CW+1)'(V_VISIBLE_AREA);
   localparam logic [CW:0] HS_START  = (CW+1)'(H_VISIBLE_AREA + H_FRONT_PORCH);
   localparam logic [CW:0] HS_END    = (CW+1)'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
   localparam logic [CW:0] VS_START  = (CW+1)'(V_VISIBLE_AREA + V_FRONT_PORCH);
   localparam logic [CW:0] VS_END    = (CW+1)'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);

   logic [CW-1:0] x_q, x_d;
   logic [CW-1:0] y_q, y_d;
   logic [7:0]    fc_q, fc_d;

   logic [CW:0] x_ext_s, y_ext_s;
   logic        active_s;
   logic        hs_raw_s, vs_raw_s;

   // Counter next-state: X every enabled cycle, Y on X wrap, frame count on full wrap
   always_comb begin
      x_d  = x_q;
      y_d  = y_q;
      fc_d = fc_q;
      if (EN) begin
         if (x_q == H_LAST) begin
            x_d = {CW{1'b0}};
            if (y_q == V_LAST) begin
               y_d  = {CW{1'b0}};
               fc_d = fc_q + 8'd1;
            end else begin
               y_d  = y_q + CW'(1);
            end
         end else begin
            x_d = x_q + CW'(1);
         end
      end else begin
         x_d = x_q;
      end
   end

   // Counter registers with synchronous active-low reset
   always_ff @(posedge VGA_CLK) begin
      if (!VGA_RST_N) begin
         x_q  <= {CW{1'b0}};
         y_q  <= {CW{1'b0}};
         fc_q <= 8'd0;
      end else begin
         x_q  <= x_d;
         y_q  <= y_d;
         fc_q <= fc_d;
      end
   end

   assign x_ext_s  = {1'b0, x_q};
   assign y_ext_s  = {1'b0, y_q};
   assign active_s = (x_ext_s < H_VIS_END) && (y_ext_s < V_VIS_END);
   // VSYNC decodes Y only, so it can change only on the X wrap edge.
   assign hs_raw_s = ((x_ext_s >= HS_START) && (x_ext_s < HS_END)) ^ HSYNC_POLARITY;
   assign vs_raw_s = ((y_ext_s >= VS_START) && (y_ext_s < VS_END)) ^ VSYNC_POLARITY;

   assign X           = x_q;
   assign Y           = y_q;
   assign ACTIVE      = active_s;
   assign LINE_START  = (x_q == {CW{1'b0}});
   assign FRAME_START = (x_q == {CW{1'b0}}) && (y_q == {CW{1'b0}});
   assign FRAME_COUNT = fc_q;

   generate
      if (PIPE_DELAY == 0) begin : g_nodelay
         assign VGA_HS = hs_raw_s;
         assign VGA_VS = vs_raw_s;
         assign VGA_DE = active_s;
      end else begin : g_delay
         logic [PIPE_DELAY-1:0] hs_pipe_q;
         logic [PIPE_DELAY-1:0] vs_pipe_q;
         logic [PIPE_DELAY-1:0] de_pipe_q;

         // Sync/DE delay line, advancing only on enabled cycles
         always_ff @(posedge VGA_CLK) begin
            if (!VGA_RST_N) begin
               hs_pipe_q <= {PIPE_DELAY{HSYNC_POLARITY}};
               vs_pipe_q <= {PIPE_DELAY{VSYNC_POLARITY}};
               de_pipe_q <= {PIPE_DELAY{1'b0}};
            end else if (EN) begin
               hs_pipe_q[0] <= hs_raw_s;
               vs_pipe_q[0] <= vs_raw_s;
               de_pipe_q[0] <= active_s;
               for (int i = 1; i < PIPE_DELAY; i++) begin
                  hs_pipe_q[i] <= hs_pipe_q[i-1];
                  vs_pipe_q[i] <= vs_pipe_q[i-1];
                  de_pipe_q[i] <= de_pipe_q[i-1];
               end
            end else begin
               hs_pipe_q <= hs_pipe_q;
               vs_pipe_q <= vs_pipe_q;
               de_pipe_q <= de_pipe_q;
            end
         end

         assign VGA_HS = hs_pipe_q[PIPE_DELAY-1];
         assign VGA_VS = vs_pipe_q[PIPE_DELAY-1];
         assign VGA_DE = de_pipe_q[PIPE_DELAY-1];
      end
   endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: four parameterisations driven by shared
// random EN/reset; expectations come from the count of enabled cycles since reset.
module tb_vga_timing_gen;

   typedef struct {
      int hv, hf, hs, hb, vv, vf, vs, vb, hp, vp, d;
   } cfg_t;

   typedef struct packed {
      logic [15:0] x;
      logic [15:0] y;
      logic        active;
      logic        ls;
      logic        fs;
      logic [7:0]  fc;
      logic        hs;
      logic        vs;
      logic        de;
   } exp_t;

   typedef exp_t [3:0] exp4_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;

   logic [10:0] x_o   [4];
   logic [10:0] y_o   [4];
   logic        act_o [4];
   logic        ls_o  [4];
   logic        fs_o  [4];
   logic [7:0]  fc_o  [4];
   logic        hs_o  [4];
   logic        vs_o  [4];
   logic        de_o  [4];

   cfg_t   cfg [4];
   exp4_t  sb_q [$];
   longint n_en = 0;
   int     checks = 0;
   int     errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(.H_VISIBLE_AREA(16), .H_FRONT_PORCH(4), .H_SYNC_PULSE(6), .H_BACK_PORCH(5),
      .V_VISIBLE_AREA(10), .V_FRONT_PORCH(2), .V_SYNC_PULSE(3), .V_BACK_PORCH(4),
      .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0), .PIPE_DELAY(2), .CW(11)) dut0 (
      .VGA_CLK(clk), .VGA_RST_N(rst_n), .EN(en), .X(x_o[0]), .Y(y_o[0]), .ACTIVE(act_o[0]),
      .LINE_START(ls_o[0]), .FRAME_START(fs_o[0]), .FRAME_COUNT(fc_o[0]),
      .VGA_HS(hs_o[0]), .VGA_VS(vs_o[0]), .VGA_DE(de_o[0]));

   vga_timing_gen #(.H_VISIBLE_AREA(12), .H_FRONT_PORCH(3), .H_SYNC_PULSE(5), .H_BACK_PORCH(4),
      .V_VISIBLE_AREA(8), .V_FRONT_PORCH(1), .V_SYNC_PULSE(2), .V_BACK_PORCH(3),
      .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1), .PIPE_DELAY(3), .CW(11)) dut1 (
      .VGA_CLK(clk), .VGA_RST_N(rst_n), .EN(en), .X(x_o[1]), .Y(y_o[1]), .ACTIVE(act_o[1]),
      .LINE_START(ls_o[1]), .FRAME_START(fs_o[1]), .FRAME_COUNT(fc_o[1]),
      .VGA_HS(hs_o[1]), .VGA_VS(vs_o[1]), .VGA_DE(de_o[1]));

   vga_timing_gen #(.H_VISIBLE_AREA(4), .H_FRONT_PORCH(1), .H_SYNC_PULSE(2), .H_BACK_PORCH(1),
      .V_VISIBLE_AREA(3), .V_FRONT_PORCH(1), .V_SYNC_PULSE(1), .V_BACK_PORCH(1),
      .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b1), .PIPE_DELAY(0), .CW(11)) dut2 (
      .VGA_CLK(clk), .VGA_RST_N(rst_n), .EN(en), .X(x_o[2]), .Y(y_o[2]), .ACTIVE(act_o[2]),
      .LINE_START(ls_o[2]), .FRAME_START(fs_o[2]), .FRAME_COUNT(fc_o[2]),
      .VGA_HS(hs_o[2]), .VGA_VS(vs_o[2]), .VGA_DE(de_o[2]));

   vga_timing_gen dut3 (
      .VGA_CLK(clk), .VGA_RST_N(rst_n), .EN(en), .X(x_o[3]), .Y(y_o[3]), .ACTIVE(act_o[3]),
      .LINE_START(ls_o[3]), .FRAME_START(fs_o[3]), .FRAME_COUNT(fc_o[3]),
      .VGA_HS(hs_o[3]), .VGA_VS(vs_o[3]), .VGA_DE(de_o[3]));

   // Reference: the raster position is just the enabled-cycle count folded by the totals.
   function automatic exp_t model(input cfg_t c, input longint n);
      exp_t   e;
      longint ht, vt, m, xm, ym, xs, ys;
      ht = c.hv + c.hf + c.hs + c.hb;
      vt = c.vv + c.vf + c.vs + c.vb;
      xs = n % ht;
      ys = (n / ht) % vt;
      e.x      = 16'(xs);
      e.y      = 16'(ys);
      e.active = (xs < c.vv * 0 + c.hv) && (ys < c.vv);
      e.ls     = (xs == 0);
      e.fs     = (xs == 0) && (ys == 0);
      e.fc     = 8'((n / (ht * vt)) % 256);
      if (n < c.d) begin
         e.hs = c.hp[0];
         e.vs = c.vp[0];
         e.de = 1'b0;
      end else begin
         m    = n - c.d;
         xm   = m % ht;
         ym   = (m / ht) % vt;
         e.hs = ((xm >= c.hv + c.hf) && (xm < c.hv + c.hf + c.hs)) ^ c.hp[0];
         e.vs = ((ym >= c.vv + c.vf) && (ym < c.vv + c.vf + c.vs)) ^ c.vp[0];
         e.de = (xm < c.hv) && (ym < c.vv);
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pop each expected snapshot and compare it with the live outputs
   always @(negedge clk) begin
      exp4_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         for (int i = 0; i < 4; i++) begin
            check($sformatf("d%0d_x", i),   {5'd0, x_o[i]},   e[i].x);
            check($sformatf("d%0d_y", i),   {5'd0, y_o[i]},   e[i].y);
            check($sformatf("d%0d_act", i), {15'd0, act_o[i]}, {15'd0, e[i].active});
            check($sformatf("d%0d_ls", i),  {15'd0, ls_o[i]},  {15'd0, e[i].ls});
            check($sformatf("d%0d_fs", i),  {15'd0, fs_o[i]},  {15'd0, e[i].fs});
            check($sformatf("d%0d_fc", i),  {8'd0, fc_o[i]},   {8'd0, e[i].fc});
            check($sformatf("d%0d_hs", i),  {15'd0, hs_o[i]},  {15'd0, e[i].hs});
            check($sformatf("d%0d_vs", i),  {15'd0, vs_o[i]},  {15'd0, e[i].vs});
            check($sformatf("d%0d_de", i),  {15'd0, de_o[i]},  {15'd0, e[i].de});
         end
      end
   end

   task automatic step(input logic r, input logic e_in);
      exp4_t ex;
      @(negedge clk);
      rst_n = r;
      en    = e_in;
      @(posedge clk);
      if (!r) begin
         n_en = 0;
      end else if (e_in) begin
         n_en++;
      end
      for (int i = 0; i < 4; i++) begin
         ex[i] = model(cfg[i], n_en);
      end
      sb_q.push_back(ex);
   endtask

   initial begin
      cfg[0] = '{16, 4, 6, 5, 10, 2, 3, 4, 0, 0, 2};
      cfg[1] = '{12, 3, 5, 4, 8, 1, 2, 3, 1, 1, 3};
      cfg[2] = '{4, 1, 2, 1, 3, 1, 1, 1, 0, 1, 0};
      cfg[3] = '{800, 40, 128, 88, 600, 1, 4, 23, 0, 0, 2};

      for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 1200; i++) step(1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(0, 399) != 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
      end
      step(1'b0, 1'b0);
      for (int i = 0; i < 14000; i++) step(1'b1, 1'b1);
      @(negedge clk);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator: the next generation of the `vga_test` timing core, running in the pixel-clock domain of the DE10-Lite VGA path. It produces pixel coordinates, an active-video flag, and line and frame strobes for an upstream pixel source. It also outputs HSYNC/VSYNC/DE delayed by a configurable number of cycles, so the syncs stay aligned with a pipelined pixel source. Pixel data is not generated here.

## Interface
Parameters:
- H_VISIBLE_AREA, 800, visible pixels per line
- H_FRONT_PORCH, 40, horizontal front porch (clocks)
- H_SYNC_PULSE, 128, HSYNC width (clocks)
- H_BACK_PORCH, 88, horizontal back porch (clocks)
- V_VISIBLE_AREA, 600, visible lines per frame
- V_FRONT_PORCH, 1, vertical front porch (lines)
- V_SYNC_PULSE, 4, VSYNC width (lines)
- V_BACK_PORCH, 23, vertical back porch (lines)
- HSYNC_POLARITY, 1'b0, 0 = positive pulse (idle low, active high); 1 = negative pulse (idle high, active low)
- VSYNC_POLARITY, 1'b0, same encoding as HSYNC_POLARITY
- PIPE_DELAY, 2, register stages on VGA_HS/VGA_VS/VGA_DE (legal range 0..15)
- CW, 11, coordinate counter width; must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL)

Ports:
- VGA_CLK, in, 1, pixel clock; single clock domain
- VGA_RST_N, in, 1, synchronous active-low reset
- EN, in, 1, clock enable for the whole block
- X, out, CW, horizontal counter
- Y, out, CW, vertical counter
- ACTIVE, out, 1, X < H_VISIBLE_AREA and Y < V_VISIBLE_AREA; undelayed
- LINE_START, out, 1, high when X == 0; undelayed
- FRAME_START, out, 1, high when X == 0 and Y == 0; undelayed
- FRAME_COUNT, out, 8, completed-frame counter
- VGA_HS, out, 1, HSYNC delayed by PIPE_DELAY
- VGA_VS, out, 1, VSYNC delayed by PIPE_DELAY
- VGA_DE, out, 1, ACTIVE delayed by PIPE_DELAY

## Operation
- Totals:
  - H_TOTAL = sum of the four H_ parameters (default 1056).
  - V_TOTAL = sum of the four V_ parameters (default 628).
- Region order per axis: visible, front porch, sync, back porch.
- Counters:
  - X and Y are registers.
  - When EN = 1, X increments each clock and wraps from H_TOTAL−1 to 0.
  - Y increments only on the X wrap, and wraps from V_TOTAL−1 to 0.
  - FRAME_COUNT increments modulo 256 on the cycle where X and Y both wrap.
- Sync regions:
  - Raw HSYNC is active for H_VISIBLE_AREA+H_FRONT_PORCH ≤ X ≤ H_VISIBLE_AREA+H_FRONT_PORCH+H_SYNC_PULSE−1. Defaults: 840..967.
  - Raw VSYNC is active for V_VISIBLE_AREA+V_FRONT_PORCH ≤ Y ≤ V_VISIBLE_AREA+V_FRONT_PORCH+V_SYNC_PULSE−1. Defaults: 601..604.
  - VSYNC is line-aligned: it changes only on cycles where X == 0.
- Polarity: output level = active XOR POLARITY. When POLARITY = 1, the active level is low.
- Decoded flags: ACTIVE, LINE_START, FRAME_START and the raw sync/DE levels are combinational decodes of the current X/Y.
- Delay pipeline:
  - Raw HS/VS/DE pass through PIPE_DELAY register stages to reach VGA_HS/VGA_VS/VGA_DE.
  - PIPE_DELAY = 0 means the outputs are the direct decode.
- EN = 0: X, Y, FRAME_COUNT and every delay stage hold their values. The delay pipeline also advances only when EN = 1.
- Reset (VGA_RST_N low at a clock edge):
  - X = 0, Y = 0, FRAME_COUNT = 0.
  - Every delay stage is loaded with its inactive level: HS = HSYNC_POLARITY, VS = VSYNC_POLARITY, DE = 0.
  - Reset has priority over EN.
  - Reset mid-frame aborts the frame; no partial-frame FRAME_COUNT increment occurs.

## Timing
- Reset values during and immediately after reset:
  - X = 0, Y = 0, so ACTIVE = 1, LINE_START = 1, FRAME_START = 1.
  - FRAME_COUNT = 0.
  - VGA_HS and VGA_VS at their inactive levels; VGA_DE = 0.
  - The delayed outputs hold the reset level until PIPE_DELAY enabled cycles have elapsed (none for PIPE_DELAY = 0).
- Latency: VGA_HS/VGA_VS/VGA_DE at enabled cycle n+PIPE_DELAY equal the raw decode at enabled cycle n.
- Period with defaults:
  - Line = 1056 clocks.
  - Frame = 663168 clocks = 16,579,200 ns at 40 MHz (SVGA 800x600 @ 60 Hz).
- FRAME_START spacing: exactly H_TOTAL×V_TOTAL enabled cycles between assertions; each assertion is 1 cycle wide.
- Simultaneous events:
  - The wrap from X = H_TOTAL−1, Y = V_TOTAL−1 goes to (0,0) in one cycle.
  - On that same edge FRAME_COUNT increments; it wraps from 255 to 0.

## Test plan
- Reset with default parameters: hold VGA_RST_N low 5 cycles, then release. Required:
  - X = 0, Y = 0, FRAME_START = 1.
  - VGA_HS = 0, VGA_VS = 0, VGA_DE = 0.
  - VGA_DE rises exactly 2 cycles after release.
- One line with defaults and PIPE_DELAY = 0:
  - ACTIVE is high for 800 cycles.
  - VGA_HS is high for X = 840..967 (128 cycles).
  - LINE_START pulses every 1056 cycles.
- One full frame with defaults:
  - VGA_VS is high for Y = 601..604 (4×1056 cycles) and changes only when X == 0.
  - Consecutive FRAME_STARTs are 663168 cycles apart.
  - FRAME_COUNT goes 0 → 1.
- PIPE_DELAY = 3, HSYNC_POLARITY = VSYNC_POLARITY = 1:
  - VGA_HS falls 3 cycles after X = 840.
  - VGA_DE falls 3 cycles after X = 800.
  - VGA_HS idles high.
- EN held low for 10 cycles at X = 500:
  - X stays 500 and all outputs are frozen.
  - When EN returns high, X resumes at 501.
- Reset asserted at Y = 300, X = 123:
  - Next cycle X = 0, Y = 0, FRAME_COUNT = 0.
  - Delayed outputs are at their inactive levels.
  - FRAME_START is high on the first cycle after release.
